// File: rtl/sys_sched_pkg.sv
// sys_sched_pkg: shared encodings for the system-instruction scheduler.
// Rev 1.0 - initial release.
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

package sys_sched_pkg;

  localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;
  localparam logic [2:0]  F3_PRIV      = 3'b000;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
  localparam logic [31:0] INSTR_FENCEI = 32'h0000_100F;

  localparam logic [1:0]  ST_IDLE      = 2'd0;
  localparam logic [1:0]  ST_EXEC      = 2'd1;
  localparam logic [1:0]  ST_FLUSH     = 2'd2;

  // A CSR op (SYSTEM, non-zero funct3) only produces a result when rd is not x0.
  function automatic logic csr_writes_rd(input logic [31:0] instr);
    return (instr[6:0] == OPC_SYSTEM) && (instr[14:12] != F3_PRIV) && (instr[11:7] != 5'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sys_sched_lane_pick.sv
// sys_sched_lane_pick: lowest-index one-hot priority picker with binary index.
// Rev 1.0 - initial release.
`default_nettype none

module sys_sched_lane_pick #(
  parameter int LANES = 4,
  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] req_i,
  output logic [LANES-1:0] onehot_o,
  output logic [IDXW-1:0]  idx_o,
  output logic             any_o
);

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IDXW'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/sys_sched.sv
// sys_sched: age-ordered arbiter of system instructions onto the single sys_csr unit.
// Optional interrupt injection under `SYS_IRQ_EN. Rev 1.0 - initial release.
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module sys_sched
  import sys_sched_pkg::*;
#(
  parameter int LANES = 4,
  parameter int XLEN  = `XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      req_vld_i,
  input  logic [LANES*XLEN-1:0] req_instr_i,
  input  logic [LANES*XLEN-1:0] req_pc_i,
  input  logic [LANES*XLEN-1:0] req_rs0_i,
  output logic [LANES-1:0]      req_ack_o,
  output logic                  busy_o,
  output logic [XLEN-1:0]       sys_instr_o,
  output logic [XLEN-1:0]       sys_pc_o,
  output logic                  sys_vld_o,
  output logic [XLEN-1:0]       sys_rs0_o,
  input  logic                  sys_jump_vld_i,
  input  logic [XLEN-1:0]       sys_jump_pc_i,
  input  logic [XLEN-1:0]       sys_csr_data_i,
`ifdef SYS_IRQ_EN
  input  logic                  irq_req_i,
  input  logic [XLEN-1:0]       irq_pc_i,
  output logic                  irq_ack_o,
`endif
  output logic                  wb_vld_o,
  output logic [4:0]            wb_rd_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic                  flush_vld_o,
  output logic [XLEN-1:0]       flush_pc_o
);

  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d, pc_q, pc_d, rs0_q, rs0_d;
  logic            wb_vld_q, wb_vld_d, flush_vld_q, flush_vld_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d, flush_pc_q, flush_pc_d;

  logic [LANES-1:0] pick_oh;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_any, take_lane, take_irq;

  sys_sched_lane_pick #(.LANES(LANES)) u_pick (
    .req_i    (req_vld_i),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Reset wins over a same-cycle grant so nothing is acked that will be dropped.
`ifdef SYS_IRQ_EN
  assign take_irq  = (state_q == ST_IDLE) && irq_req_i && !rst;
  assign irq_ack_o = take_irq;
`else
  assign take_irq  = 1'b0;
`endif
  assign take_lane = (state_q == ST_IDLE) && pick_any && !take_irq && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      pc_q        <= '0;
      rs0_q       <= '0;
      wb_vld_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      flush_vld_q <= 1'b0;
      flush_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      rs0_q       <= rs0_d;
      wb_vld_q    <= wb_vld_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      flush_vld_q <= flush_vld_d;
      flush_pc_q  <= flush_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (take_irq || take_lane) state_d = ST_EXEC;
      ST_EXEC:  state_d = sys_jump_vld_i ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_d     = instr_q;
    pc_d        = pc_q;
    rs0_d       = rs0_q;
    wb_vld_d    = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    flush_vld_d = 1'b0;
    flush_pc_d  = flush_pc_q;
`ifdef SYS_IRQ_EN
    if (take_irq) begin
      instr_d = XLEN'(INSTR_ECALL);
      pc_d    = irq_pc_i;
      rs0_d   = '0;
    end else
`endif
    if (take_lane) begin
      instr_d = req_instr_i[int'(pick_idx)*XLEN +: XLEN];
      pc_d    = req_pc_i[int'(pick_idx)*XLEN +: XLEN];
      rs0_d   = req_rs0_i[int'(pick_idx)*XLEN +: XLEN];
    end
    if (state_q == ST_EXEC) begin
      wb_vld_d    = csr_writes_rd(instr_q[31:0]);
      wb_rd_d     = instr_q[11:7];
      wb_data_d   = sys_csr_data_i;
      flush_vld_d = sys_jump_vld_i;
      if (sys_jump_vld_i) flush_pc_d = sys_jump_pc_i;
    end
  end

  always_comb begin
    req_ack_o = take_lane ? pick_oh : '0;
    busy_o    = (state_q != ST_IDLE);
    sys_vld_o = (state_q == ST_EXEC);
  end

  assign sys_instr_o = instr_q;
  assign sys_pc_o    = pc_q;
  assign sys_rs0_o   = rs0_q;
  assign wb_vld_o    = wb_vld_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign flush_vld_o = flush_vld_q;
  assign flush_pc_o  = flush_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_sys_sched.sv
// tb_sys_sched: directed table, corner sequences and randomized run against a reference model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_sys_sched;

  localparam int LANES = 4;
  localparam int XLEN  = 32;
  localparam int NR    = 400;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] FENCEI = 32'h0000_100F;
  localparam logic [31:0] MTVEC  = 32'h0000_0080;
  localparam logic [31:0] MEPC   = 32'h0000_1000;
  localparam logic [31:0] CSRRW5 = 32'h3052_92F3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [LANES-1:0]      req_vld;
  logic [XLEN-1:0]       l_instr [LANES];
  logic [XLEN-1:0]       l_pc    [LANES];
  logic [XLEN-1:0]       l_rs0   [LANES];
  logic [LANES*XLEN-1:0] req_instr, req_pc, req_rs0;
  logic [LANES-1:0]      req_ack;
  logic                  busy, sys_vld, sys_jump_vld, wb_vld, flush_vld;
  logic [XLEN-1:0]       sys_instr, sys_pc, sys_rs0, sys_jump_pc, sys_csr_data;
  logic [4:0]            wb_rd;
  logic [XLEN-1:0]       wb_data, flush_pc;
`ifdef SYS_IRQ_EN
  logic                  irq_req, irq_ack;
  logic [XLEN-1:0]       irq_pc;
`endif

  always_comb begin
    req_instr = '0;
    req_pc    = '0;
    req_rs0   = '0;
    for (int i = 0; i < LANES; i++) begin
      req_instr[i*XLEN +: XLEN] = l_instr[i];
      req_pc[i*XLEN +: XLEN]    = l_pc[i];
      req_rs0[i*XLEN +: XLEN]   = l_rs0[i];
    end
  end

  // sys_csr stand-in: fixed CSR contents, jumps for ecall/mret/fence.i
  function automatic logic [31:0] csr_read(input logic [31:0] ins);
    return (ins[31:20] == 12'h305) ? MTVEC : {20'hC5A00, ins[31:20]};
  endfunction
  function automatic logic jumps(input logic [31:0] ins);
    return (ins == ECALL) || (ins == MRET) || (ins == FENCEI);
  endfunction
  function automatic logic [31:0] jump_tgt(input logic [31:0] ins, input logic [31:0] pc);
    if (ins == ECALL) return MTVEC;
    if (ins == MRET)  return MEPC;
    return pc + 32'd4;
  endfunction

  assign sys_jump_vld = sys_vld && jumps(sys_instr);
  assign sys_jump_pc  = jump_tgt(sys_instr, sys_pc);
  assign sys_csr_data = csr_read(sys_instr);

  sys_sched #(.LANES(LANES), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_vld_i      (req_vld),
    .req_instr_i    (req_instr),
    .req_pc_i       (req_pc),
    .req_rs0_i      (req_rs0),
    .req_ack_o      (req_ack),
    .busy_o         (busy),
    .sys_instr_o    (sys_instr),
    .sys_pc_o       (sys_pc),
    .sys_vld_o      (sys_vld),
    .sys_rs0_o      (sys_rs0),
    .sys_jump_vld_i (sys_jump_vld),
    .sys_jump_pc_i  (sys_jump_pc),
    .sys_csr_data_i (sys_csr_data),
`ifdef SYS_IRQ_EN
    .irq_req_i      (irq_req),
    .irq_pc_i       (irq_pc),
    .irq_ack_o      (irq_ack),
`endif
    .wb_vld_o       (wb_vld),
    .wb_rd_o        (wb_rd),
    .wb_data_o      (wb_data),
    .flush_vld_o    (flush_vld),
    .flush_pc_o     (flush_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic filler_lanes();
    for (int i = 0; i < LANES; i++) begin
      l_instr[i] = 32'hDEAD0000 | i;
      l_pc[i]    = 32'h9000 + i * 4;
      l_rs0[i]   = 32'h5A5A0000 + i;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 5))
      0: return ECALL;
      1: return MRET;
      2: return FENCEI;
      3: return {12'($urandom_range(0, 4095)), 5'($urandom_range(0, 31)),
                 3'($urandom_range(1, 7)), 5'($urandom_range(1, 31)), 7'h73};
      4: return {12'($urandom_range(0, 4095)), 5'($urandom_range(0, 31)),
                 3'($urandom_range(1, 7)), 5'd0, 7'h73};
      default: return 32'h1050_0073;
    endcase
  endfunction

  typedef struct {
    int          lane;
    logic [3:0]  vld;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs0;
    logic [3:0]  ack;
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        fl;
    logic [31:0] fpc;
  } vec_t;

  vec_t vecs [6];

  logic        e_sv [NR+4];
  logic [31:0] e_si [NR+4];
  logic [31:0] e_sp [NR+4];
  logic [31:0] e_sr [NR+4];
  logic        e_wb [NR+4];
  logic [4:0]  e_rd [NR+4];
  logic [31:0] e_wd [NR+4];
  logic        e_fl [NR+4];
  logic [31:0] e_fp [NR+4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 4'b0001, CSRRW5,        32'h040, 32'h100, 4'b0001, 1'b1, 5'd5, MTVEC,         1'b0, 32'h0};
    vecs[1] = '{1, 4'b1010, 32'h3401E3F3,  32'h044, 32'h003, 4'b0010, 1'b1, 5'd7, 32'hC5A00340,  1'b0, 32'h0};
    vecs[2] = '{2, 4'b0100, 32'h3000A073,  32'h048, 32'h011, 4'b0100, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0};
    vecs[3] = '{3, 4'b1000, FENCEI,        32'h200, 32'h000, 4'b1000, 1'b0, 5'd0, 32'h0,         1'b1, 32'h204};
    vecs[4] = '{2, 4'b1100, ECALL,         32'h300, 32'h000, 4'b0100, 1'b0, 5'd0, 32'h0,         1'b1, MTVEC};
    vecs[5] = '{0, 4'b1111, MRET,          32'h500, 32'h000, 4'b0001, 1'b0, 5'd0, 32'h0,         1'b1, MEPC};
    for (int i = 0; i < NR + 4; i++) begin
      e_sv[i] = 1'b0; e_si[i] = '0; e_sp[i] = '0; e_sr[i] = '0;
      e_wb[i] = 1'b0; e_rd[i] = '0; e_wd[i] = '0; e_fl[i] = 1'b0; e_fp[i] = '0;
    end

    rst     = 1'b1;
    req_vld = '0;
`ifdef SYS_IRQ_EN
    irq_req = 1'b0;
    irq_pc  = '0;
`endif
    filler_lanes();
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_sys_vld", sys_vld, 0);
    chk("rst_wb_vld", wb_vld, 0);
    chk("rst_flush_vld", flush_vld, 0);
    chk("rst_sys_instr", sys_instr, 0);
    chk("rst_flush_pc", flush_pc, 0);

    // directed table: grant, one EXEC cycle, then wb/flush result
    for (int v = 0; v < 6; v++) begin
      step();
      filler_lanes();
      l_instr[vecs[v].lane] = vecs[v].instr;
      l_pc[vecs[v].lane]    = vecs[v].pc;
      l_rs0[vecs[v].lane]   = vecs[v].rs0;
      req_vld               = vecs[v].vld;
      @(negedge clk);
      chk("tbl_ack", req_ack, vecs[v].ack);
      chk("tbl_idle_busy", busy, 0);
      step();
      req_vld = '0;
      @(negedge clk);
      chk("tbl_sys_vld", sys_vld, 1);
      chk("tbl_busy", busy, 1);
      chk("tbl_sys_instr", sys_instr, vecs[v].instr);
      chk("tbl_sys_pc", sys_pc, vecs[v].pc);
      chk("tbl_sys_rs0", sys_rs0, vecs[v].rs0);
      step();
      @(negedge clk);
      chk("tbl_sys_vld_off", sys_vld, 0);
      chk("tbl_wb_vld", wb_vld, vecs[v].wb);
      if (vecs[v].wb) begin
        chk("tbl_wb_rd", wb_rd, vecs[v].rd);
        chk("tbl_wb_data", wb_data, vecs[v].data);
      end
      chk("tbl_flush_vld", flush_vld, vecs[v].fl);
      chk("tbl_flush_busy", busy, vecs[v].fl);
      if (vecs[v].fl) chk("tbl_flush_pc", flush_pc, vecs[v].fpc);
    end

    // lanes 0 and 2 together: strictly serialized
    step();
    filler_lanes();
    l_instr[0] = CSRRW5;
    l_instr[2] = 32'h3401E3F3;
    req_vld    = 4'b0101;
    @(negedge clk);
    chk("s1_ack0", req_ack, 4'b0001);
    step();
    req_vld = 4'b0100;
    @(negedge clk);
    chk("s1_hold", req_ack, 4'b0000);
    chk("s1_sys0", sys_instr, CSRRW5);
    step();
    @(negedge clk);
    chk("s1_ack2", req_ack, 4'b0100);
    chk("s1_gap", sys_vld, 0);
    step();
    req_vld = '0;
    @(negedge clk);
    chk("s1_sys2_vld", sys_vld, 1);
    chk("s1_sys2", sys_instr, 32'h3401E3F3);

    // ecall on lane 1 flushes; lane 3 squashed during FLUSH
    step();
    filler_lanes();
    l_instr[1] = ECALL;
    l_pc[1]    = 32'h700;
    l_instr[3] = CSRRW5;
    req_vld    = 4'b1010;
    @(negedge clk);
    chk("s2_ack1", req_ack, 4'b0010);
    step();
    req_vld = 4'b1000;
    @(negedge clk);
    chk("s2_exec_noack", req_ack, 4'b0000);
    step();
    @(negedge clk);
    chk("s2_flush_vld", flush_vld, 1);
    chk("s2_flush_pc", flush_pc, MTVEC);
    chk("s2_squash", req_ack, 4'b0000);
    step();
    @(negedge clk);
    chk("s2_reack3", req_ack, 4'b1000);
    chk("s2_flush_off", flush_vld, 0);
    step();
    req_vld = '0;
    @(negedge clk);
    chk("s2_sys3", sys_instr, CSRRW5);

    // reset during EXEC drops the instruction; reset beats a same-cycle request
    step();
    step();
    filler_lanes();
    l_instr[0] = CSRRW5;
    req_vld    = 4'b0001;
    @(negedge clk);
    chk("s3_ack", req_ack, 4'b0001);
    step();
    req_vld = '0;
    rst     = 1'b1;
    @(negedge clk);
    chk("s3_exec", sys_vld, 1);
    step();
    req_vld = 4'b0001;
    @(negedge clk);
    chk("s3_rst_ack", req_ack, 4'b0000);
    chk("s3_wb_vld", wb_vld, 0);
    chk("s3_flush_vld", flush_vld, 0);
    chk("s3_sys_vld", sys_vld, 0);
    chk("s3_busy", busy, 0);
    chk("s3_sys_instr", sys_instr, 0);
    step();
    rst     = 1'b0;
    req_vld = '0;
    @(negedge clk);
    chk("s3_no_late_wb", wb_vld, 0);
    chk("s3_idle", busy, 0);

`ifdef SYS_IRQ_EN
    step();
    filler_lanes();
    l_instr[0] = CSRRW5;
    req_vld    = 4'b0001;
    irq_req    = 1'b1;
    irq_pc     = 32'h600;
    @(negedge clk);
    chk("irq_ack", irq_ack, 1);
    chk("irq_lane_wait", req_ack, 4'b0000);
    step();
    irq_req = 1'b0;
    @(negedge clk);
    chk("irq_sys_instr", sys_instr, ECALL);
    chk("irq_sys_pc", sys_pc, 32'h600);
    chk("irq_sys_rs0", sys_rs0, 0);
    step();
    @(negedge clk);
    chk("irq_flush_pc", flush_pc, MTVEC);
    chk("irq_flush_vld", flush_vld, 1);
    step();
    @(negedge clk);
    chk("irq_lane0_ack", req_ack, 4'b0001);
    step();
    req_vld = '0;
    step();
`endif

    // randomized run: grant k at n -> sys at n+1 -> wb/flush at n+2, free again at n+2 or n+3
    begin : rnd
      int          free_at;
      logic        exp_busy;
      logic [3:0]  exp_ack;
      logic [31:0] ins, pc;
      int          k;
      free_at = 0;
      for (int n = 0; n < NR; n++) begin
        step();
        for (int i = 0; i < LANES; i++) begin
          l_instr[i] = rand_instr();
          l_pc[i]    = $urandom & 32'hFFFF_FFFC;
          l_rs0[i]   = $urandom;
        end
        req_vld  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
        exp_busy = (n < free_at);
        exp_ack  = '0;
        if (!exp_busy && req_vld != '0) begin
          k = 0;
          while (!req_vld[k]) k++;
          exp_ack[k] = 1'b1;
          ins        = l_instr[k];
          pc         = l_pc[k];
          e_sv[n+1]  = 1'b1;
          e_si[n+1]  = ins;
          e_sp[n+1]  = pc;
          e_sr[n+1]  = l_rs0[k];
          e_wb[n+2]  = (ins[6:0] == 7'h73) && (ins[14:12] != 3'd0) && (ins[11:7] != 5'd0);
          e_rd[n+2]  = ins[11:7];
          e_wd[n+2]  = csr_read(ins);
          e_fl[n+2]  = jumps(ins);
          e_fp[n+2]  = jump_tgt(ins, pc);
          free_at    = n + (jumps(ins) ? 3 : 2);
        end
        @(negedge clk);
        chk("rnd_ack", req_ack, exp_ack);
        chk("rnd_busy", busy, exp_busy);
        chk("rnd_sys_vld", sys_vld, e_sv[n]);
        if (e_sv[n]) begin
          chk("rnd_sys_instr", sys_instr, e_si[n]);
          chk("rnd_sys_pc", sys_pc, e_sp[n]);
          chk("rnd_sys_rs0", sys_rs0, e_sr[n]);
        end
        chk("rnd_wb_vld", wb_vld, e_wb[n]);
        if (e_wb[n]) begin
          chk("rnd_wb_rd", wb_rd, e_rd[n]);
          chk("rnd_wb_data", wb_data, e_wd[n]);
        end
        chk("rnd_flush_vld", flush_vld, e_fl[n]);
        if (e_fl[n]) chk("rnd_flush_pc", flush_pc, e_fp[n]);
      end
    end

    req_vld = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
